// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a carry register for ADDC.
// Optional build macro ALU_PIPE_SAT_EN enables unsigned saturating ADDSU (12) / SUBSU (13).
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       oper,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_RSUB = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_XNOR = 4'd6;
    localparam logic [3:0] OP_ZERO = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_ADDC = 4'd11;
`ifdef ALU_PIPE_SAT_EN
    localparam logic [3:0] OP_ADDSU = 4'd12;
    localparam logic [3:0] OP_SUBSU = 4'd13;
`endif

    // Signed overflow from MSBs; for subtraction x is the minuend.
    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] r);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [3:0]       s1_op_q, s1_op_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;
    logic             carry_q, carry_d;

    logic             s2_load;
    logic             accept;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             res_c;
    logic             res_v;
    logic [SHW-1:0]   sh;

    assign sh = s1_b_q[SHW-1:0];

    // Handshake: in_ready depends on out_ready and stage state, never on in_valid.
    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        accept   = in_valid && in_ready;
    end

    // Operation datapath evaluated from the stage-1 registers.
    always_comb begin
        ext   = {(WIDTH+1){1'b0}};
        res   = {WIDTH{1'b0}};
        res_c = 1'b0;
        res_v = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                ext   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = add_ovf(s1_a_q, s1_b_q, ext[WIDTH-1:0]);
            end
            OP_SUB: begin
                ext   = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = sub_ovf(s1_a_q, s1_b_q, ext[WIDTH-1:0]);
            end
            OP_RSUB: begin
                ext   = {1'b0, s1_b_q} - {1'b0, s1_a_q};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = sub_ovf(s1_b_q, s1_a_q, ext[WIDTH-1:0]);
            end
            OP_OR:   res = s1_a_q | s1_b_q;
            OP_AND:  res = s1_a_q & s1_b_q;
            OP_XOR:  res = s1_a_q ^ s1_b_q;
            OP_XNOR: res = ~(s1_a_q ^ s1_b_q);
            OP_ZERO: res = {WIDTH{1'b0}};
            OP_SHL:  res = s1_a_q << sh;
            OP_SHR:  res = s1_a_q >> sh;
            OP_SRA:  res = $signed(s1_a_q) >>> sh;
            OP_ADDC: begin
                ext   = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, carry_q};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = add_ovf(s1_a_q, s1_b_q, ext[WIDTH-1:0]);
            end
`ifdef ALU_PIPE_SAT_EN
            OP_ADDSU: begin
                ext = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                if (ext[WIDTH]) begin
                    res   = {WIDTH{1'b1}};
                    res_c = 1'b1;
                end else begin
                    res   = ext[WIDTH-1:0];
                    res_c = 1'b0;
                end
            end
            OP_SUBSU: begin
                ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                if (ext[WIDTH]) begin
                    res   = {WIDTH{1'b0}};
                    res_c = 1'b1;
                end else begin
                    res   = ext[WIDTH-1:0];
                    res_c = 1'b0;
                end
            end
`endif
            default: res = {WIDTH{1'b0}};
        endcase
    end

    // Next-state for both stages and the carry register.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_c_d    = flag_c_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_v_d    = flag_v_q;
        carry_d     = carry_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = oper;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // carry follows every load so ADDC sees its predecessor in accept order.
        if (s2_load) begin
            out_valid_d = 1'b1;
            result_d    = res;
            flag_c_d    = res_c;
            flag_z_d    = (res == {WIDTH{1'b0}});
            flag_n_d    = res[WIDTH-1];
            flag_v_d    = res_v;
            carry_d     = res_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_op_q     <= 4'd0;
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            flag_c_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_c_q    <= flag_c_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): arithmetic reference model plus literal expectations.
module tb_alu_pipe;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_s;
    logic [7:0] b_s;
    logic [3:0] op_s;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_c, flag_z, flag_n, flag_v;

    int total = 0;
    int bad   = 0;

    logic [11:0] mq[$];    // expected {c,z,n,v,result} in accept order
    logic [11:0] hist[$];  // DUT outputs actually transferred
    logic        mcarry;
    logic        held_v;
    logic [11:0] held;
    int          ridx = 0;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_s), .b(b_s), .oper(op_s), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y,
                                          input logic [3:0] op, input logic cin);
        int ua, ub, sa, sb, r, sr, shamt;
        logic c, v;
        logic [7:0] res;
        ua = int'(x); ub = int'(y);
        sa = int'($signed(x)); sb = int'($signed(y));
        shamt = ub % 8;
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            4'd0: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            4'd1: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 127) || (sr < -128); end
            4'd2: begin r = ub - ua; c = (ub < ua); sr = sb - sa; v = (sr > 127) || (sr < -128); end
            4'd3: r = ua | ub;
            4'd4: r = ua & ub;
            4'd5: r = ua ^ ub;
            4'd6: r = ~(ua ^ ub);
            4'd8: r = ua << shamt;
            4'd9: r = ua >> shamt;
            4'd10: r = sa >>> shamt;
            4'd11: begin
                r = ua + ub + int'(cin); c = (r > 255);
                sr = sa + sb + int'(cin); v = (sr > 127) || (sr < -128);
            end
`ifdef ALU_PIPE_SAT_EN
            4'd12: begin if (ua + ub > 255) begin r = 255; c = 1'b1; end else r = ua + ub; end
            4'd13: begin if (ua < ub) begin r = 0; c = 1'b1; end else r = ua - ub; end
`endif
            default: r = 0;
        endcase
        res = r[7:0];
        return {c, (res == 8'h00), res[7], v, res};
    endfunction

    // Compare process: tracks accepts into the model, checks every transfer and stall hold.
    always @(negedge clk) begin
        logic [11:0] cur, exp;
        if (!rst_n) begin
            mq.delete();
            mcarry = 1'b0;
            held_v = 1'b0;
        end else begin
            cur = {flag_c, flag_z, flag_n, flag_v, result};
            if (held_v) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", cur, held);
            end
            if (out_valid) begin
                if (mq.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else if (out_ready) begin
                    exp = mq.pop_front();
                    chk("model", cur, exp);
                    hist.push_back(cur);
                end
            end
            held_v = out_valid && !out_ready;
            held   = cur;
            if (in_valid && in_ready) begin
                exp = model(a_s, b_s, op_s, mcarry);
                mcarry = exp[11];
                mq.push_back(exp);
            end
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top);
        int n = 0;
        logic acc;
        in_valid = 1'b1; a_s = ta; b_s = tb; op_s = top;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string nm, input logic [7:0] r, input logic [3:0] f);
        int n = 0;
        while (hist.size() <= ridx && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (hist.size() <= ridx) begin
            chk({nm, "_timeout"}, hist.size(), ridx + 1);
        end else begin
            chk({nm, "_res"}, hist[ridx][7:0], r);
            chk({nm, "_czn_v"}, hist[ridx][11:8], f);
        end
        ridx++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_s = 8'h00; b_s = 8'h00; op_s = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {flag_c, flag_z, flag_n, flag_v}, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Single op latency: accept at N, out_valid seen only after N+1.
        send(8'hF0, 8'h20, 4'd0);
        idle();
        @(negedge clk);
        chk("lat_before", out_valid, 0);
        @(negedge clk);
        chk("lat_after", out_valid, 1);
        expect_res("lone_add", 8'h10, 4'b1000);

        // Carry chain back-to-back, then with an output stall.
        send(8'hF0, 8'h20, 4'd0);
        send(8'h01, 8'h01, 4'd11);
        idle();
        expect_res("chain_add", 8'h10, 4'b1000);
        expect_res("chain_addc", 8'h03, 4'b0000);

        out_ready = 1'b0;
        send(8'hF0, 8'h20, 4'd0);
        send(8'h01, 8'h01, 4'd11);
        idle();
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        expect_res("gap_add", 8'h10, 4'b1000);
        expect_res("gap_addc", 8'h03, 4'b0000);

        // Assorted ops and boundaries.
        send(8'h05, 8'h07, 4'd1);
        send(8'h7F, 8'h01, 4'd0);
        send(8'hAA, 8'h55, 4'd6);
        send(8'h80, 8'h03, 4'd10);
        send(8'h80, 8'h03, 4'd9);
        send(8'h81, 8'h09, 4'd8);
        send(8'h12, 8'h34, 4'd14);
        idle();
        expect_res("sub_borrow", 8'hFE, 4'b1010);
        expect_res("add_ovf", 8'h80, 4'b0011);
        expect_res("xnor_zero", 8'h00, 4'b0100);
        expect_res("sra", 8'hF0, 4'b0010);
        expect_res("shr", 8'h10, 4'b0000);
        expect_res("shl_mod", 8'h02, 4'b0000);
        expect_res("reserved14", 8'h00, 4'b0100);

        // Six ops streamed into a stalled sink.
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                send(8'h0C, 8'h30, 4'd3);
                send(8'hF0, 8'h3C, 4'd4);
                send(8'h03, 8'h10, 4'd2);
                send(8'hFF, 8'h0F, 4'd5);
                send(8'h12, 8'h34, 4'd7);
                send(8'h80, 8'h01, 4'd1);
                idle();
            end
            begin
                logic [7:0] snap;
                repeat (3) @(negedge clk);
                chk("stream_in_ready_low", in_ready, 0);
                snap = result;
                repeat (2) @(negedge clk);
                chk("stream_stable", result, snap);
                chk("stream_in_ready_still_low", in_ready, 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    chk("stream_no_gap", out_valid, 1);
                end
            end
        join
        expect_res("st_or", 8'h3C, 4'b0000);
        expect_res("st_and", 8'h30, 4'b0000);
        expect_res("st_rsub", 8'h0D, 4'b0000);
        expect_res("st_xor", 8'hF0, 4'b0010);
        expect_res("st_zero", 8'h00, 4'b0100);
        expect_res("st_sub_ovf", 8'h7F, 4'b0001);

        // Reset with two ops in flight discards them and clears the carry.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'hF0, 8'h20, 4'd0);
        send(8'h11, 8'h22, 4'd5);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'h01, 8'h01, 4'd11);
        idle();
        expect_res("addc_after_reset", 8'h02, 4'b0000);

        // Saturating opcodes (reserved when the feature is absent).
        send(8'hF0, 8'h20, 4'd12);
        send(8'h05, 8'h07, 4'd13);
        idle();
`ifdef ALU_PIPE_SAT_EN
        expect_res("addsu", 8'hFF, 4'b1010);
        expect_res("subsu", 8'h00, 4'b1100);
`else
        expect_res("addsu_rsvd", 8'h00, 4'b0100);
        expect_res("subsu_rsvd", 8'h00, 4'b0100);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("drained_model", mq.size(), 0);
        chk("drained_hist", hist.size(), ridx);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined ALU. It is the successor to the 8-bit combinational ALU.
- Adds: generic data width, 4-bit opcode space with shifts and carry-chained add, status flags, and a valid/ready handshake on input and output.
- Sits between an operand source (sequencer/register file) and a result sink. Both ends may stall.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2 and a power of 2.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  synchronous reset, active-low.
in_valid  input  1  operand/opcode valid.
in_ready  output  1  block can accept an operand this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B; low SHW bits are the shift amount for shift ops.
oper  input  4  opcode.
out_valid  output  1  result valid.
out_ready  input  1  sink accepts result.
result  output  WIDTH  registered result.
flag_c  output  1  carry/borrow.
flag_z  output  1  result == 0.
flag_n  output  1  result MSB.
flag_v  output  1  signed overflow.

Behaviour:
- Reset:
  - Reset is sampled on clk while rst_n == 0.
  - Clears: out_valid=0, result=0, all flags=0, stage-1 valid=0, internal carry register carry_q=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight ops; no partial result appears.
- Pipeline:
  - S1 registers {a,b,oper} on in_valid&&in_ready.
  - The op is computed combinationally from S1 and loaded into the output register (S2).
  - Latency: accept at edge N gives out_valid=1 after edge N+1. Throughput is 1 op/cycle with no stall.
- Handshake:
  - S2 loads when S1 valid and (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_load.
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - Transfer occurs only when valid&&ready.
  - While out_valid && !out_ready: result and flags hold stable, and out_valid stays 1.
  - Maximum 2 ops in flight. Order is preserved and no op is dropped or duplicated.
- Arithmetic: extended width is WIDTH+1, zero-extended.
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 RSUB: b-a.
  - 3 OR.
  - 4 AND.
  - 5 XOR.
  - 6 XNOR.
  - 7 ZERO: result 0.
  - 8 SHL: a << b[SHW-1:0].
  - 9 SHR: logical a >> b[SHW-1:0].
  - 10 SRA: arithmetic a >>> b[SHW-1:0].
  - 11 ADDC: a+b+carry_q.
  - 12-15: result 0, unless the optional feature is compiled in.
- Flags, captured with result at the S2 load:
  - flag_c = bit WIDTH of the extended result for ops 0,1,2,11. For SUB/RSUB this is the borrow, 1 when the minuend is less than the subtrahend. flag_c=0 for all other ops.
  - flag_v = signed overflow for ops 0,1,2,11, computed from the operand and result MSBs; 0 otherwise.
  - flag_z and flag_n are computed from result for every op.
- carry_q:
  - Updated to flag_c on every S2 load, including loads of non-arithmetic ops.
  - ADDC therefore uses the carry of the immediately preceding op in accept order, regardless of stall timing.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined:
  - Opcode 12 ADDSU = unsigned saturating a+b; clamps to all-ones on carry, flag_c=1 when clamped.
  - Opcode 13 SUBSU = unsigned saturating a-b; clamps to 0 on borrow, flag_c=1 when clamped.
  - flag_v=0 for both.
- Undefined: opcodes 12/13 behave as reserved (result 0, flag_c=0, flag_v=0, flag_z=1).
- All other behaviour is identical in both builds.

Test Plan:
All scenarios use WIDTH=8 unless stated.
- Reset, then idle: out_valid=0, result=0x00, all flags 0, in_ready=1.
- ADD 0xF0+0x20, then ADDC 0x01+0x01, out_ready=1 -> 0x10 with C=1; next cycle 0x03 with C=0. Same pair with a 3-cycle out_ready=0 gap between them -> ADDC result still 0x03.
- SUB 0x05-0x07 -> 0xFE, C=1, N=1, Z=0. ADD 0x7F+0x01 -> 0x80, V=1, N=1. XNOR 0xAA,0x55 -> 0x00, Z=1.
- SRA 0x80 by b=0x03 -> 0xF0. SHR 0x80 by 3 -> 0x10. SHL 0x81 by b=0x09 (uses 3 LSBs = 1) -> 0x02.
- Stream 6 back-to-back ops with out_ready held 0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - result stays stable while stalled.
  - After release, all 6 results appear in order, with no gaps while both valid and ready are high.
- Assert rst_n=0 for one cycle with 2 ops in flight -> out_valid=0 next cycle, carry_q cleared (ADDC 0x01+0x01 -> 0x02). With ALU_PIPE_SAT_EN: ADDSU 0xF0+0x20 -> 0xFF, C=1; SUBSU 0x05-0x07 -> 0x00, C=1. Without it: both -> 0x00, Z=1.
